depth_feed_sequencer: RTL and testbench
=======================================

DEPTH_FEED_SEQUENCER -- requirements
Module: depth_feed_sequencer

Interface
REQ-001 SHALL have one clock, clk; reset rst_n is asynchronous and active-low.
REQ-002 FIFO_DEPTH, 16, live-event buffer entries; power of two, at least 4.
REQ-003 clk  in  1  clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  one-cycle pulse that begins or restarts book synchronisation.
REQ-006 snap_valid  in  1  snapshot level valid.
REQ-007 snap_ready  out  1  snapshot level accepted.
REQ-008 snap_last  in  1  final snapshot level.
REQ-009 snap_id  in  64  snapshot lastUpdateId.
REQ-010 snap_data  in  72  {side[7:0], price_f32[31:0], qty_f32[31:0]}.
REQ-011 live_valid  in  1  live depth event pulse; no backpressure.
REQ-012 live_id  in  64  live update_id.
REQ-013 live_data  in  72  same packing as snap_data.
REQ-014 out_valid  out  1  one-cycle pulse to the order book.
REQ-015 out_id  out  64  update_id of the emitted event.
REQ-016 out_data  out  72  payload of the emitted event.
REQ-017 book_clear  out  1  one-cycle pulse that clears the order book.
REQ-018 synced  out  1  high only in LIVE.
REQ-019 sync_err  out  1  one-cycle pulse on a gap or an overflow.
REQ-020 overflow  out  1  sticky flag: live event lost because the FIFO was full.
REQ-021 drop_count  out  32  count of stale or discarded live events.

Function
REQ-022 States SHALL be IDLE, SNAP, DRAIN and LIVE; the sequencer SHALL leave reset in IDLE.
- IDLE: snap_ready=0; live events discarded and counted.
- On start (from any state): book_clear pulses the same cycle, FIFO emptied, overflow cleared, next state SNAP.
REQ-023 SNAP:
- snap_ready=1.
- Each snapshot handshake SHALL drive out_valid with that level one cycle later.
- Live events are pushed into the FIFO.
- A handshake with snap_last loads last_id<=snap_id and moves to DRAIN.
REQ-024 DRAIN: one FIFO entry popped per cycle.
- Simultaneous push and pop SHALL be legal, with the occupancy count unchanged.
- DRAIN moves to LIVE on a cycle with the FIFO empty and live_valid=0.
REQ-025 ID rule in DRAIN (popped entry) and in LIVE (live input), compared at 65-bit width so there is no wrap:
- id<last_id: drop, drop_count+1.
- id==last_id or id==last_id+1: emit one cycle later, last_id<=id.
- id>last_id+1: gap; no emit, sync_err pulse, FIFO emptied, next state IDLE.
REQ-026 Live push while the FIFO is full, in SNAP or DRAIN:
- the event is lost;
- overflow<=1, sync_err pulse, next state IDLE.
REQ-027 out_valid SHALL never exceed one pulse per cycle.
REQ-028 out_id/out_data SHALL hold their last values when out_valid=0.
REQ-029 drop_count SHALL saturate at 0xFFFFFFFF.
REQ-030 start coincident with a snapshot handshake or a live event: start wins, and that input is discarded.

Reset
REQ-031 Asserting rst_n low SHALL, asynchronously and at any time including mid-snapshot or mid-drain, force:
- state IDLE, FIFO empty, last_id=0;
- all outputs 0 (out_valid, out_id, out_data, book_clear, snap_ready, synced, sync_err, overflow, drop_count).
REQ-032 Deassertion SHALL NOT emit book_clear or out_valid.

Configuration
REQ-033 Macro DEPTH_SEQ_STATS_EN defined: drop_count SHALL be implemented as specified.
REQ-034 Macro DEPTH_SEQ_STATS_EN undefined: drop_count SHALL be constant 0, with no counter logic; all other behaviour is unchanged.

Verification
REQ-035 Reset, then live_valid id=5 -> no out_valid, drop_count=1, synced=0.
REQ-036 start; 3 snap levels with snap_id=100 (last on the third); live ids 99,100,101 arrive during SNAP:
- book_clear pulse;
- 3 snapshot outputs;
- then outputs with ids 100,101 in order;
- drop_count=1, synced=1.
REQ-037 In LIVE with last_id=101, live id=103 -> no out_valid, sync_err pulse, state IDLE, synced=0.
REQ-038 In SNAP, FIFO_DEPTH+1 live events with no snap_last -> overflow=1, sync_err pulse, state IDLE.
REQ-039 rst_n low mid-DRAIN with 5 entries queued -> all outputs 0 immediately; after release, no out_valid until a new start.
REQ-040 DEPTH_SEQ_STATS_EN undefined, scenario REQ-036 -> identical outputs, except drop_count=0.

Source files
------------

// File: rtl/depth_feed_sequencer.sv
// Order-book feed sequencer: replays a depth snapshot, then splices buffered and live depth
// events by update_id. Define DEPTH_SEQ_STATS_EN to build the drop_count statistics counter.
module depth_feed_sequencer #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        snap_valid,
  output logic        snap_ready,
  input  logic        snap_last,
  input  logic [63:0] snap_id,
  input  logic [71:0] snap_data,
  input  logic        live_valid,
  input  logic [63:0] live_id,
  input  logic [71:0] live_data,
  output logic        out_valid,
  output logic [63:0] out_id,
  output logic [71:0] out_data,
  output logic        book_clear,
  output logic        synced,
  output logic        sync_err,
  output logic        overflow,
  output logic [31:0] drop_count
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StSnap, StDrain, StLive} state_e;

  state_e        state_q;
  logic [135:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [63:0]   last_id_q;

  logic          fifo_full, fifo_empty, buffering;
  logic          live_evt, snap_hs, push, pop, ovf, flush;
  logic          chk_en, is_stale, is_gap, is_ok;
  logic [135:0]  head;
  logic [63:0]   chk_id;
  logic [71:0]   chk_data;
  logic [64:0]   id_w, last_w;

  assign fifo_full  = count_q == (AW + 1)'(FIFO_DEPTH);
  assign fifo_empty = count_q == '0;
  assign head       = mem_q[rd_ptr_q];
  assign buffering  = (state_q == StSnap) || (state_q == StDrain);

  assign snap_ready = state_q == StSnap;
  assign synced     = state_q == StLive;
  assign book_clear = start & rst_n;

  // start wins over any coincident snapshot handshake or live event
  assign live_evt = live_valid & ~start;
  assign snap_hs  = snap_valid & snap_ready & ~start;
  assign push     = live_evt & buffering & ~fifo_full;
  assign ovf      = live_evt & buffering & fifo_full;
  assign pop      = (state_q == StDrain) & ~fifo_empty & ~start;

  // One id check per cycle: the FIFO head in DRAIN, the live input in LIVE
  assign chk_en   = pop | ((state_q == StLive) & live_evt);
  assign chk_id   = (state_q == StDrain) ? head[135:72] : live_id;
  assign chk_data = (state_q == StDrain) ? head[71:0] : live_data;
  assign id_w     = {1'b0, chk_id};
  assign last_w   = {1'b0, last_id_q};
  assign is_stale = id_w < last_w;
  assign is_gap   = id_w > (last_w + 65'd1);
  assign is_ok    = chk_en & ~is_stale & ~is_gap;
  assign flush    = start | ovf | (chk_en & is_gap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {live_id, live_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      last_id_q <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_data  <= '0;
      sync_err  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      if (start) begin
        state_q  <= StSnap;
        overflow <= 1'b0;
      end else begin
        unique case (state_q)
          StSnap: begin
            if (snap_hs) begin
              out_valid <= 1'b1;
              out_id    <= snap_id;
              out_data  <= snap_data;
              if (snap_last) begin
                last_id_q <= snap_id;
                state_q   <= StDrain;
              end
            end
          end
          StDrain, StLive: begin
            if (is_ok) begin
              out_valid <= 1'b1;
              out_id    <= chk_id;
              out_data  <= chk_data;
              last_id_q <= chk_id;
            end
            if (chk_en && is_gap) begin
              sync_err <= 1'b1;
              state_q  <= StIdle;
            end else if (state_q == StDrain && fifo_empty && !live_valid) begin
              state_q <= StLive;
            end
          end
          default: ;
        endcase
        // A lost live event invalidates the whole sync attempt
        if (ovf) begin
          overflow <= 1'b1;
          sync_err <= 1'b1;
          state_q  <= StIdle;
        end
      end
    end
  end

`ifdef DEPTH_SEQ_STATS_EN
  logic        drop_inc;
  logic [31:0] drop_count_q;

  assign drop_inc = ((state_q == StIdle) & live_evt) | (chk_en & is_stale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count_q <= '0;
    end else if (drop_inc && drop_count_q != 32'hFFFF_FFFF) begin
      drop_count_q <= drop_count_q + 32'd1;
    end
  end

  assign drop_count = drop_count_q;
`else
  assign drop_count = 32'd0;
`endif

endmodule

// File: tb/tb_depth_feed_sequencer.sv
// Randomised and directed bench for depth_feed_sequencer against a queue-based behavioural model.
module tb_depth_feed_sequencer;
  localparam int DEPTH = 16;
  localparam int M_IDLE = 0, M_SNAP = 1, M_DRAIN = 2, M_LIVE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, snap_valid = 1'b0, snap_last = 1'b0, live_valid = 1'b0;
  logic [63:0] snap_id = '0, live_id = '0;
  logic [71:0] snap_data = '0, live_data = '0;
  logic        snap_ready, out_valid, book_clear, synced, sync_err, overflow;
  logic [63:0] out_id;
  logic [71:0] out_data;
  logic [31:0] drop_count;

  int n_checks = 0;
  int n_errors = 0;
  int n_out = 0;

  // Reference model state
  int           m_st;
  logic [135:0] m_q[$];
  logic [64:0]  m_last;
  logic         m_ov, m_err, m_ovf;
  logic [63:0]  m_oid;
  logic [71:0]  m_odata;
  logic [31:0]  m_drops;

  depth_feed_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .snap_valid(snap_valid), .snap_ready(snap_ready), .snap_last(snap_last),
    .snap_id(snap_id), .snap_data(snap_data),
    .live_valid(live_valid), .live_id(live_id), .live_data(live_data),
    .out_valid(out_valid), .out_id(out_id), .out_data(out_data),
    .book_clear(book_clear), .synced(synced), .sync_err(sync_err),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_drop(input logic [31:0] n);
`ifdef DEPTH_SEQ_STATS_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [71:0] rand72();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[71:0];
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_q.delete(); m_last = '0; m_ov = 0; m_err = 0; m_ovf = 0;
    m_oid = '0; m_odata = '0; m_drops = '0;
  endtask

  task automatic count_drop();
    if (m_drops != 32'hFFFF_FFFF) m_drops++;
  endtask

  task automatic emit(input logic [63:0] id, input logic [71:0] d);
    m_ov = 1; m_oid = id; m_odata = d;
  endtask

  task automatic lose_event();
    m_ovf = 1; m_err = 1; m_st = M_IDLE; m_q.delete();
  endtask

  // Stale ids are dropped, last_id or last_id+1 are emitted, anything further ahead is a gap
  task automatic apply_rule(input logic [63:0] id, input logic [71:0] d, output bit gap);
    logic [64:0] idw;
    idw = {1'b0, id};
    gap = 0;
    if (idw < m_last) count_drop();
    else if (idw <= m_last + 65'd1) begin emit(id, d); m_last = idw; end
    else begin gap = 1; m_err = 1; m_st = M_IDLE; m_q.delete(); end
  endtask

  task automatic model_step();
    bit was_full, was_empty, gap;
    logic [135:0] e;
    m_ov = 0; m_err = 0; gap = 0;
    was_full  = (m_q.size() == DEPTH);
    was_empty = (m_q.size() == 0);
    if (start) begin
      m_q.delete(); m_ovf = 0; m_st = M_SNAP;
    end else begin
      case (m_st)
        M_IDLE: if (live_valid) count_drop();
        M_SNAP: begin
          if (snap_valid) begin
            emit(snap_id, snap_data);
            if (snap_last) begin m_last = {1'b0, snap_id}; m_st = M_DRAIN; end
          end
          if (live_valid) begin
            if (was_full) lose_event();
            else m_q.push_back({live_id, live_data});
          end
        end
        M_DRAIN: begin
          if (!was_empty) begin
            e = m_q.pop_front();
            apply_rule(e[135:72], e[71:0], gap);
          end
          if (live_valid) begin
            if (was_full) lose_event();
            else if (!gap) m_q.push_back({live_id, live_data});
          end else if (was_empty) begin
            m_st = M_LIVE;
          end
        end
        default: if (live_valid) apply_rule(live_id, live_data, gap);
      endcase
    end
  endtask

  // One clock: combinational check before the edge, model step, registered checks after it
  task automatic tick();
    @(negedge clk);
    check_eq("book_clear", book_clear, start);
    model_step();
    @(posedge clk);
    #1;
    if (out_valid) n_out++;
    check_eq("out_valid", out_valid, m_ov);
    check_eq("out_id", out_id, m_oid);
    check_eq("out_data", out_data, m_odata);
    check_eq("sync_err", sync_err, m_err);
    check_eq("overflow", overflow, m_ovf);
    check_eq("drop_count", drop_count, exp_drop(m_drops));
    check_eq("synced", synced, m_st == M_LIVE);
    check_eq("snap_ready", snap_ready, m_st == M_SNAP);
  endtask

  task automatic drive(input bit st, input bit sv, input bit sl, input logic [63:0] sid,
                       input logic [71:0] sd, input bit lv, input logic [63:0] lid,
                       input logic [71:0] ld);
    start = st; snap_valid = sv; snap_last = sl; snap_id = sid; snap_data = sd;
    live_valid = lv; live_id = lid; live_data = ld;
    tick();
  endtask

  task automatic idle_inputs();
    start = 0; snap_valid = 0; snap_last = 0; live_valid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_id", out_id, 64'd0);
    check_eq("rst_out_data", out_data, 72'd0);
    check_eq("rst_book_clear", book_clear, 1'b0);
    check_eq("rst_snap_ready", snap_ready, 1'b0);
    check_eq("rst_synced", synced, 1'b0);
    check_eq("rst_sync_err", sync_err, 1'b0);
    check_eq("rst_overflow", overflow, 1'b0);
    check_eq("rst_drop_count", drop_count, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] base, lid;
    int nsnap;
    bit sv, sl, lv, st;

    do_reset();

    // Live event while idle is discarded and counted
    drive(0, 0, 0, 0, 0, 1, 64'd5, rand72());
    check_eq("r35_out_valid", out_valid, 1'b0);
    check_eq("r35_drop", drop_count, exp_drop(32'd1));
    check_eq("r35_synced", synced, 1'b0);

    // Snapshot of three levels with live 99,100,101 buffered meanwhile
    do_reset();
    n_out = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 64'd100, rand72(), 1, 64'd99, rand72());
    drive(0, 1, 0, 64'd100, rand72(), 1, 64'd100, rand72());
    drive(0, 1, 1, 64'd100, rand72(), 1, 64'd101, rand72());
    repeat (5) drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("r36_outputs", n_out, 5);
    check_eq("r36_last_out_id", out_id, 64'd101);
    check_eq("r36_drop", drop_count, exp_drop(32'd1));
    check_eq("r36_synced", synced, 1'b1);

    // Gap in LIVE
    drive(0, 0, 0, 0, 0, 1, 64'd103, rand72());
    check_eq("r37_out_valid", out_valid, 1'b0);
    check_eq("r37_sync_err", sync_err, 1'b1);
    check_eq("r37_synced", synced, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("r37_err_pulse", sync_err, 1'b0);

    // FIFO overflow during SNAP
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i <= DEPTH; i++) drive(0, 0, 0, 0, 0, 1, 64'd500 + 64'(i), rand72());
    check_eq("r38_overflow", overflow, 1'b1);
    check_eq("r38_sync_err", sync_err, 1'b1);
    check_eq("r38_snap_ready", snap_ready, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("r38_sticky", overflow, 1'b1);

    // Reset mid-DRAIN with five entries still queued
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      drive(0, 1, i == 5, 64'd200, rand72(), 1, 64'd201 + 64'(i), rand72());
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    n_out = 0;
    repeat (5) drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("r39_no_output", n_out, 0);

    // Randomised sync episodes
    for (int ep = 0; ep < 40; ep++) begin
      base = (ep % 8 == 7) ? 64'hFFFF_FFFF_FFFF_FFFD : {$urandom(), $urandom()};
      lid = base - 64'd2;
      drive(1, 1'($urandom_range(0, 1)), 0, base, rand72(), 1'($urandom_range(0, 1)), lid,
            rand72());
      nsnap = 0;
      for (int c = 0; c < 50; c++) begin
        sv = ($urandom_range(0, 1) == 0);
        sl = sv && (nsnap >= 3) && ($urandom_range(0, 3) == 0);
        lv = ($urandom_range(0, 9) < 4);
        st = ($urandom_range(0, 99) == 0);
        if (lv) lid = lid + (($urandom_range(0, 29) == 0) ? 64'd2 : 64'($urandom_range(0, 1)));
        if ($urandom_range(0, 199) == 0) do_reset();
        else drive(st, sv, sl, base, rand72(), lv, lid, rand72());
        if (sv) nsnap++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
